// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver feeding a small byte FIFO; bytes appear one cycle after the stop-bit sample.
// Consumer pops on valid_o && ready_i; a push into a full FIFO without a same-cycle pop is dropped and sets a sticky overflow flag.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             r_sync1, r_sync2, r_rxs_d;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_overflow;
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr;

  logic w_rxs, w_push, w_pop, w_full, w_empty;

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          // Mid start bit: a high line here was a glitch, not a frame.
          if (r_cnt == HALF) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rxs, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_frame_err <= !w_rxs;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push  = (r_state == S_STOP) && (r_cnt == LAST) && w_rxs;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop   = !w_empty && ready_i;

  // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        if (!w_full || w_pop) begin
          r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift;
          r_wptr                     <= r_wptr + 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign data_o      = r_mem[r_rptr[FIFO_AW-1:0]];
  assign valid_o     = !w_empty;
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_overflow;
  assign busy_o      = (r_state != S_IDLE);

endmodule
